// File: rtl/mips_core_pkg.sv
// Shared types for the MIPS core: HI/LO unit opcodes and multiply/divide sequencer states.
package mips_core_pkg;

  // Operations understood by the multiply/divide unit.
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MFHI  = 3'd4,
    MD_MFLO  = 3'd5,
    MD_MTHI  = 3'd6,
    MD_MTLO  = 3'd7
  } MdOp;

  // Sequencer states: IDLE accepts requests, MUL/DIV iterate, FIX applies signs and commits HI/LO.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } md_state_e;

  // True for the operations that work on two's-complement operands.
  function automatic logic md_op_is_signed(input MdOp op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply (1, 2 or 4 bits per cycle),
// restoring divide (1 bit per cycle), sign fix-up in a final cycle, MFHI/MFLO/MTHI/MTLO access.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module muldiv_unit
  import mips_core_pkg::*;
#(
  parameter int DATA_WIDTH         = `DATA_WIDTH,  // even, >= 8
  parameter int MUL_BITS_PER_CYCLE = 1             // 1, 2 or 4; must divide DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  MdOp                   req_op,
  input  logic [DATA_WIDTH-1:0] req_op1,
  input  logic [DATA_WIDTH-1:0] req_op2,
  input  logic                  flush,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_result,
  output logic                  busy
);

  localparam int W     = DATA_WIDTH;
  localparam int K     = MUL_BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] MUL_ITERS = CNT_W'(W / K);
  localparam logic [CNT_W-1:0] DIV_ITERS = CNT_W'(W);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  md_state_e          state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  // Multiply: {partial product high, remaining multiplier bits}. Divide: {remainder, quotient/dividend}.
  logic [2*W-1:0]     prod_reg, prod_next;
  // Multiplicand magnitude (multiply) or divisor magnitude (divide).
  logic [W-1:0]       mcand_reg, mcand_next;
  logic               is_div_reg, is_div_next;
  logic               neg_q_reg, neg_q_next;   // product sign, or quotient sign
  logic               neg_r_reg, neg_r_next;   // remainder sign
  logic [W-1:0]       hi_reg, hi_next;
  logic [W-1:0]       lo_reg, lo_next;
  logic               resp_valid_reg, resp_valid_next;
  logic [W-1:0]       resp_result_reg, resp_result_next;

  logic               accept;
  logic               s1, s2;
  logic [W-1:0]       abs1, abs2;

  // Multiply step datapath
  logic [W+K-1:0]     pp [K];
  logic [W+K-1:0]     mul_sum;
  logic [2*W-1:0]     mul_step;

  // Divide step datapath
  logic [W:0]         div_shift;
  logic [W-1:0]       div_diff;
  logic               div_ge;
  logic [2*W-1:0]     div_step;

  // Commit values produced in FIX
  logic [2*W-1:0]     prod_fix;

  assign req_ready   = (state_reg == IDLE) && !flush;
  assign accept      = req_valid && req_ready;
  assign busy        = (state_reg != IDLE);
  assign resp_valid  = resp_valid_reg;
  assign resp_result = resp_result_reg;

  // Signed ops iterate on magnitudes; MIN maps onto itself, which is correct as an unsigned magnitude.
  assign s1   = md_op_is_signed(req_op) && req_op1[W-1];
  assign s2   = md_op_is_signed(req_op) && req_op2[W-1];
  assign abs1 = s1 ? -req_op1 : req_op1;
  assign abs2 = s2 ? -req_op2 : req_op2;

  // One shifted multiplicand per multiplier bit retired this cycle.
  for (genvar gi = 0; gi < K; gi++) begin : g_pp
    assign pp[gi] = prod_reg[gi] ? (({{K{1'b0}}, mcand_reg}) << gi) : '0;
  end

  // Sum the partial products into the running high half, then shift K multiplier bits out.
  always_comb begin
    mul_sum = {{K{1'b0}}, prod_reg[2*W-1:W]};
    for (int i = 0; i < K; i++) begin
      mul_sum = mul_sum + pp[i];
    end
    mul_step = {mul_sum, prod_reg[W-1:K]};
  end

  // Restoring divide: shift in the next dividend bit and subtract the divisor when it fits.
  always_comb begin
    div_shift = prod_reg[2*W-1:W-1];
    div_ge    = (div_shift >= {1'b0, mcand_reg});
    div_diff  = div_shift[W-1:0] - mcand_reg;
    div_step  = div_ge ? {div_diff, prod_reg[W-2:0], 1'b1}
                       : {prod_reg[2*W-2:0], 1'b0};
    prod_fix  = neg_q_reg ? -prod_reg : prod_reg;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath, HI/LO and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg         <= '0;
      prod_reg        <= '0;
      mcand_reg       <= '0;
      is_div_reg      <= 1'b0;
      neg_q_reg       <= 1'b0;
      neg_r_reg       <= 1'b0;
      hi_reg          <= '0;
      lo_reg          <= '0;
      resp_valid_reg  <= 1'b0;
      resp_result_reg <= '0;
    end else begin
      cnt_reg         <= cnt_next;
      prod_reg        <= prod_next;
      mcand_reg       <= mcand_next;
      is_div_reg      <= is_div_next;
      neg_q_reg       <= neg_q_next;
      neg_r_reg       <= neg_r_next;
      hi_reg          <= hi_next;
      lo_reg          <= lo_next;
      resp_valid_reg  <= resp_valid_next;
      resp_result_reg <= resp_result_next;
    end
  end

  // Next-state and datapath control; flush always wins and never touches HI/LO.
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    prod_next        = prod_reg;
    mcand_next       = mcand_reg;
    is_div_next      = is_div_reg;
    neg_q_next       = neg_q_reg;
    neg_r_next       = neg_r_reg;
    hi_next          = hi_reg;
    lo_next          = lo_reg;
    resp_valid_next  = 1'b0;
    resp_result_next = '0;

    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          unique case (req_op)
            MD_MULT, MD_MULTU: begin
              state_next  = MUL;
              cnt_next    = MUL_ITERS;
              prod_next   = {{W{1'b0}}, abs2};
              mcand_next  = abs1;
              is_div_next = 1'b0;
              neg_q_next  = s1 ^ s2;
              neg_r_next  = 1'b0;
            end
            MD_DIV, MD_DIVU: begin
              is_div_next = 1'b1;
              if (req_op2 == '0) begin
                // Divide by zero skips iteration: LO = all ones, HI = raw dividend.
                state_next = FIX;
                cnt_next   = '0;
                prod_next  = {req_op1, {W{1'b1}}};
                mcand_next = '0;
                neg_q_next = 1'b0;
                neg_r_next = 1'b0;
              end else begin
                state_next = DIV;
                cnt_next   = DIV_ITERS;
                prod_next  = {{W{1'b0}}, abs1};
                mcand_next = abs2;
                neg_q_next = s1 ^ s2;
                neg_r_next = s1;
              end
            end
            MD_MFHI: begin
              resp_valid_next  = 1'b1;
              resp_result_next = hi_reg;
            end
            MD_MFLO: begin
              resp_valid_next  = 1'b1;
              resp_result_next = lo_reg;
            end
            MD_MTHI: hi_next = req_op1;
            MD_MTLO: lo_next = req_op1;
            default: ;
          endcase
        end
      end
      MUL: begin
        prod_next = mul_step;
        cnt_next  = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) begin
          state_next = FIX;
        end
      end
      DIV: begin
        prod_next = div_step;
        cnt_next  = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = IDLE;
        cnt_next   = '0;
        if (!flush) begin
          if (is_div_reg) begin
            hi_next = neg_r_reg ? -prod_reg[2*W-1:W] : prod_reg[2*W-1:W];
            lo_next = neg_q_reg ? -prod_reg[W-1:0]   : prod_reg[W-1:0];
          end else begin
            hi_next = prod_fix[2*W-1:W];
            lo_next = prod_fix[W-1:0];
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (flush) begin
      state_next = IDLE;
      cnt_next   = '0;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, a randomized model-checked pass,
// flush/reset cases, and a MUL_BITS_PER_CYCLE=4 instance. MF responses go through a scoreboard.
`timescale 1ns/1ps
module tb_muldiv_unit;
  import mips_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  MdOp         req_op = MD_MFHI;
  logic [31:0] req_op1 = '0;
  logic [31:0] req_op2 = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic [31:0] resp_result;
  logic        busy;

  logic        req_valid4 = 1'b0;
  logic        req_ready4;
  MdOp         req_op4 = MD_MFHI;
  logic [31:0] req_op1_4 = '0;
  logic [31:0] req_op2_4 = '0;
  logic        flush4 = 1'b0;
  logic        resp_valid4;
  logic [31:0] resp_result4;
  logic        busy4;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    int          at;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  muldiv_unit #(.DATA_WIDTH(32), .MUL_BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_op1(req_op1), .req_op2(req_op2), .flush(flush),
    .resp_valid(resp_valid), .resp_result(resp_result), .busy(busy)
  );

  muldiv_unit #(.DATA_WIDTH(32), .MUL_BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid4), .req_ready(req_ready4),
    .req_op(req_op4), .req_op1(req_op1_4), .req_op2(req_op2_4), .flush(flush4),
    .resp_valid(resp_valid4), .resp_result(resp_result4), .busy(busy4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Response monitor: pops the scoreboard on every MF response, checks data and timing.
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_valid) begin
        if (sb_q.size() == 0) begin
          check("resp_unexpected", 64'(resp_valid), 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("resp_data", 64'(resp_result), 64'(e.data));
          check("resp_cycle", 64'(cyc), 64'(e.at));
          $display("resp: result=0x%08h expected=0x%08h cycle=%0d", resp_result, e.data, cyc);
        end
      end else begin
        check("resp_idle_zero", 64'(resp_result), 64'd0);
      end
    end
  end

  // Reference model of the architectural HI/LO effect of one operation.
  task automatic model(input MdOp op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MD_MULT: begin
        p = 64'(sa * sb);
        hi_m = p[63:32];
        lo_m = p[31:0];
      end
      MD_MULTU: begin
        p = 64'(a) * 64'(b);
        hi_m = p[63:32];
        lo_m = p[31:0];
      end
      MD_DIV: begin
        if (b == 0) begin
          lo_m = 32'hFFFF_FFFF;
          hi_m = a;
        end else begin
          q = sa / sb;
          r = sa % sb;
          lo_m = q[31:0];
          hi_m = r[31:0];
        end
      end
      MD_DIVU: begin
        if (b == 0) begin
          lo_m = 32'hFFFF_FFFF;
          hi_m = a;
        end else begin
          lo_m = a / b;
          hi_m = a % b;
        end
      end
      MD_MTHI: hi_m = a;
      MD_MTLO: lo_m = a;
      default: ;
    endcase
  endtask

  // Drive one request (called at a negedge), wait for acceptance, return at the next negedge.
  task automatic issue(input MdOp op, input logic [31:0] a, input logic [31:0] b,
                       input bit upd, input logic [31:0] exp_rd, output int t_acc);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_op = op;
    req_op1 = a;
    req_op2 = b;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    t_acc = cyc;
    if (!req_ready) begin
      check("accept_timeout", 64'(req_ready), 64'd1);
      req_valid = 1'b0;
      return;
    end
    if (op == MD_MFHI || op == MD_MFLO) begin
      sb_q.push_back('{data: exp_rd, at: t_acc + 1});
    end
    if (upd) model(op, a, b);
    $display("req: op=%s op1=0x%08h op2=0x%08h accepted cycle=%0d", op.name(), a, b, t_acc);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op1 = $urandom;
    req_op2 = $urandom;
    @(negedge clk);
  endtask

  task automatic rd(input MdOp op, input logic [31:0] exp);
    int t;
    issue(op, 32'd0, 32'd0, 1'b0, exp, t);
  endtask

  task automatic wait_ready(input string tag, input int t_acc, input int exp_lat);
    int n;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(cyc - t_acc), 64'(exp_lat));
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // One request on the 4-bit/cycle instance; returns acceptance cycle (assumes it is idle).
  task automatic issue4(input MdOp op, input logic [31:0] a, input logic [31:0] b, output int t_acc);
    req_valid4 = 1'b1;
    req_op4 = op;
    req_op1_4 = a;
    req_op2_4 = b;
    check("dut4_ready", 64'(req_ready4), 64'd1);
    t_acc = cyc;
    @(posedge clk);
    #1;
    req_valid4 = 1'b0;
    req_op1_4 = $urandom;
    req_op2_4 = $urandom;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, n;
    MdOp ops[4];
    logic [31:0] a, b;
    ops[0] = MD_MULT; ops[1] = MD_MULTU; ops[2] = MD_DIV; ops[3] = MD_DIVU;

    // Reset and first-cycle state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clk);
    rd(MD_MFHI, 32'h0);
    rd(MD_MFLO, 32'h0);

    // Signed multiply, latency and MFHI stalled behind it
    issue(MD_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1, 32'h0, t);
    check("mult_busy", 64'(busy), 64'd1);
    check("mult_ready_low", 64'(req_ready), 64'd0);
    issue(MD_MFHI, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFF, t2);
    check("mult_mfhi_stall", 64'(t2 - t), 64'd34);
    rd(MD_MFLO, 32'hFFFF_FFEB);

    // Unsigned multiply, all-ones operands
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0, t);
    wait_ready("multu_lat", t, 34);
    rd(MD_MFHI, 32'hFFFF_FFFE);
    rd(MD_MFLO, 32'h0000_0001);

    // Signed divide with negative dividend
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h0, t);
    wait_ready("div_lat", t, 34);
    rd(MD_MFLO, 32'hFFFF_FFFD);
    rd(MD_MFHI, 32'hFFFF_FFFF);

    // MIN / -1
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, t);
    wait_ready("divmin_lat", t, 34);
    rd(MD_MFLO, 32'h8000_0000);
    rd(MD_MFHI, 32'h0);

    // Unsigned divide
    issue(MD_DIVU, 32'd100, 32'd7, 1'b1, 32'h0, t);
    wait_ready("divu_lat", t, 34);
    rd(MD_MFLO, 32'd14);
    rd(MD_MFHI, 32'd2);

    // Divide by zero: straight to FIX
    issue(MD_DIVU, 32'd5, 32'd0, 1'b1, 32'h0, t);
    check("div0_busy", 64'(busy), 64'd1);
    wait_ready("div0_lat", t, 2);
    rd(MD_MFLO, 32'hFFFF_FFFF);
    rd(MD_MFHI, 32'd5);
    issue(MD_DIV, 32'hFFFF_FF00, 32'd0, 1'b1, 32'h0, t);
    wait_ready("sdiv0_lat", t, 2);
    rd(MD_MFHI, 32'hFFFF_FF00);

    // Randomized pass against the model
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(0, 15)) - 32'd8 : $urandom;
      if (i == 5) b = 32'd0;
      issue(ops[i % 4], a, b, 1'b1, 32'h0, t);
      rd(MD_MFHI, hi_m);
      rd(MD_MFLO, lo_m);
    end

    // MTHI/MTLO then a multiply flushed at its 10th MUL cycle
    issue(MD_MTHI, 32'h1234, 32'h0, 1'b1, 32'h0, t);
    issue(MD_MTLO, 32'h5678, 32'h0, 1'b1, 32'h0, t);
    issue(MD_MULT, 32'd9, 32'd9, 1'b0, 32'h0, t);
    wait_until(t + 10);
    flush = 1'b1;
    check("flush_mul_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_idle_busy", 64'(busy), 64'd0);
    check("flush_idle_ready", 64'(req_ready), 64'd1);
    rd(MD_MFHI, 32'h1234);
    rd(MD_MFLO, 32'h5678);

    // Flush together with a request: nothing accepted
    req_valid = 1'b1;
    req_op = MD_MTHI;
    req_op1 = 32'hDEAD_BEEF;
    flush = 1'b1;
    #1;
    check("flush_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    rd(MD_MFHI, 32'h1234);

    // Flush during FIX leaves HI/LO untouched
    issue(MD_MULTU, 32'd3, 32'd5, 1'b0, 32'h0, t);
    wait_until(t + 33);
    check("fix_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("fix_flush_busy", 64'(busy), 64'd0);
    rd(MD_MFLO, 32'h5678);
    rd(MD_MFHI, 32'h1234);

    // Operands changed after acceptance have no effect
    issue(MD_MULTU, 32'd6, 32'd7, 1'b1, 32'h0, t);
    rd(MD_MFLO, 32'd42);

    // 4 bits/cycle instance
    issue4(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, t);
    n = 0;
    while (!req_ready4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mul4_lat", 64'(cyc - t), 64'd10);
    issue4(MD_MFHI, 32'd0, 32'd0, t);
    check("mul4_resp_valid", 64'(resp_valid4), 64'd1);
    check("mul4_hi", 64'(resp_result4), 64'hFFFF_FFFE);
    $display("resp4: MFHI result=0x%08h", resp_result4);
    issue4(MD_MFLO, 32'd0, 32'd0, t);
    check("mul4_lo", 64'(resp_result4), 64'h1);
    $display("resp4: MFLO result=0x%08h", resp_result4);

    // Asynchronous reset in the middle of a divide
    issue(MD_DIVU, 32'd1000, 32'd3, 1'b0, 32'h0, t);
    wait_until(t + 6);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_mid_resp_result", 64'(resp_result), 64'd0);
    hi_m = '0;
    lo_m = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rel_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rd(MD_MFLO, 32'h0);
    rd(MD_MFHI, 32'h0);

    repeat (2) @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
